// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: lookahead group width and the
// carry-lookahead helper equations used by the 4-bit lookahead cell.
package alu_pkg;

    localparam int GRP_W = 4;

    function automatic logic grp_gen(input logic [GRP_W-1:0] g, input logic [GRP_W-1:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    function automatic logic grp_prop(input logic [GRP_W-1:0] p);
        return &p;
    endfunction

    // Carries into each bit of a 4-bit group, all computed in parallel from ci.
    function automatic logic [GRP_W-1:0] lookahead4(input logic [GRP_W-1:0] g,
                                                    input logic [GRP_W-1:0] p,
                                                    input logic             ci);
        logic [GRP_W-1:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead cell: per-bit carries plus group G/P.
module cla_group4
    import alu_pkg::*;
(
    input  logic [GRP_W-1:0] g_i,
    input  logic [GRP_W-1:0] p_i,
    input  logic             ci_i,
    output logic [GRP_W-1:0] c_o,
    output logic             g_o,
    output logic             p_o
);

    assign c_o = lookahead4(g_i, p_i, ci_i);
    assign g_o = grp_gen(g_i, p_i);
    assign p_o = grp_prop(p_i);

endmodule

// File: rtl/cla_pipe_adder.sv
// Three-stage handshaked carry-lookahead adder with whole-word group G/P
// outputs so wider adders can cascade it.
module cla_pipe_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             g_out,
    output logic             p_out
);

    localparam int NGRP = WIDTH / GRP_W;

    logic             v1_q, v2_q, v3_q;
    logic             v1_d, v2_d, v3_d;
    logic             adv1, adv2, adv3, load1;

    logic [WIDTH-1:0] g1_q, p1_q;
    logic             cin1_q;
    logic [WIDTH-1:0] p2_q;
    logic [WIDTH:0]   c2_q;
    logic             wg2_q, wp2_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q, g_out_q, p_out_q;

    logic [NGRP-1:0]  grp_g, grp_p;
    logic [NGRP:0]    c_grp;
    logic [WIDTH-1:0] c_bit;
    logic             word_g, word_p;

    // Each stage advances only when the one below it is empty or advancing,
    // so in_ready ripples combinationally back from out_ready.
    always_comb begin
        adv3  = v3_q & out_ready;
        adv2  = v2_q & (~v3_q | adv3);
        adv1  = v1_q & (~v2_q | adv2);
        load1 = in_valid & in_ready;
        v1_d  = load1 | (v1_q & ~adv1);
        v2_d  = adv1  | (v2_q & ~adv2);
        v3_d  = adv2  | (v3_q & ~adv3);
    end

    assign in_ready = ~v1_q | adv1;

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        cla_group4 u_grp (
            .g_i  (g1_q[k*GRP_W +: GRP_W]),
            .p_i  (p1_q[k*GRP_W +: GRP_W]),
            .ci_i (c_grp[k]),
            .c_o  (c_bit[k*GRP_W +: GRP_W]),
            .g_o  (grp_g[k]),
            .p_o  (grp_p[k])
        );
    end

    if (NGRP == GRP_W) begin : g_lvl2_cell
        logic [GRP_W-1:0] c_lvl2;
        cla_group4 u_lvl2 (
            .g_i  (grp_g),
            .p_i  (grp_p),
            .ci_i (cin1_q),
            .c_o  (c_lvl2),
            .g_o  (word_g),
            .p_o  (word_p)
        );
        assign c_grp = {word_g | (word_p & cin1_q), c_lvl2};
    end else begin : g_lvl2_generic
        // Other widths fold the group G/P terms directly; word G is the
        // carry out of the word with a zero carry in.
        always_comb begin
            c_grp[0] = cin1_q;
            word_g   = 1'b0;
            for (int k = 0; k < NGRP; k++) begin
                c_grp[k+1] = grp_g[k] | (grp_p[k] & c_grp[k]);
                word_g     = grp_g[k] | (grp_p[k] & word_g);
            end
            word_p = &grp_p;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            g_out_q <= 1'b0;
            p_out_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            if (adv2) begin
                sum_q   <= p2_q ^ c2_q[WIDTH-1:0];
                cout_q  <= c2_q[WIDTH];
                g_out_q <= wg2_q;
                p_out_q <= wp2_q;
            end
        end
    end

    // NOTE: S1/S2 data registers are not reset; their valid bits already
    // mark them empty, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (load1) begin
            g1_q   <= a & b;
            p1_q   <= a ^ b;
            cin1_q <= cin;
        end
        if (adv1) begin
            p2_q  <= p1_q;
            c2_q  <= {c_grp[NGRP], c_bit};
            wg2_q <= word_g;
            wp2_q <= word_p;
        end
    end

    assign out_valid = v3_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign g_out     = g_out_q;
    assign p_out     = p_out_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Randomised scoreboard bench for cla_pipe_adder (WIDTH = 16): results are
// predicted with plain integer arithmetic at each accepting edge.
module tb_cla_pipe_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout, g_out, p_out;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         g;
        logic         p;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .g_out     (g_out),
        .p_out     (p_out)
    );

    function automatic exp_t model(logic [W-1:0] av, logic [W-1:0] bv, logic cv, int c);
        exp_t        m;
        logic [W:0]  full;
        logic [W:0]  nocarry;
        full    = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
        nocarry = {1'b0, av} + {1'b0, bv};
        m.sum   = full[W-1:0];
        m.cout  = full[W];
        m.g     = nocarry[W];
        m.p     = &(av ^ bv);
        m.cyc   = c;
        return m;
    endfunction

    // One clock: sample handshakes mid-cycle, score any consumed result,
    // record any accepted beat, then return just after the rising edge.
    task automatic step(output bit acc, output bit con, output logic [W+2:0] obs, output int lat);
        exp_t e;
        @(negedge clk);
        cyc++;
        acc = in_valid && in_ready && rst_n;
        con = out_valid && out_ready && rst_n;
        obs = {cout, sum, g_out, p_out};
        lat = -1;
        if (con) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out got sum=%h cout=%b with no beat outstanding", sum, cout);
            end else begin
                e   = q.pop_front();
                lat = cyc - e.cyc;
                if (obs !== {e.cout, e.sum, e.g, e.p}) begin
                    errors++;
                    $display("FAIL result got cout=%b sum=%h g=%b p=%b want cout=%b sum=%h g=%b p=%b",
                             cout, sum, g_out, p_out, e.cout, e.sum, e.g, e.p);
                end
            end
        end
        if (acc) q.push_back(model(a, b, cin, cyc));
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input bit chk_lat);
        bit acc, con;
        logic [W+2:0] obs;
        int lat;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            step(acc, con, obs, lat);
            if (con && chk_lat) begin
                checks++;
                if (lat !== 3) begin
                    errors++;
                    $display("FAIL latency got %0d want 3", lat);
                end
            end
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d beats outstanding want 0", q.size());
        end
    endtask

    task automatic test_reset();
        bit acc, con;
        logic [W+2:0] obs;
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a = 16'h1234; b = 16'h0001; cin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks += 3;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
            if (sum !== 16'h0000)   begin errors++; $display("FAIL rst_sum got %h want 0000", sum); end
            if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(acc, con, obs, lat);
        drain(1'b1);
    endtask

    task automatic test_carry_chain();
        bit acc, con;
        logic [W+2:0] obs;
        logic [W+2:0] got[3];
        logic [W+2:0] want[3];
        logic [W:0]   av[3];
        int lat, n;
        want[0] = {1'b1, 16'h0000, 1'b1, 1'b0};
        want[1] = {1'b0, 16'hFFFF, 1'b0, 1'b1};
        want[2] = {1'b1, 16'h0000, 1'b0, 1'b1};
        av[0] = {16'hFFFF, 1'b0};
        av[1] = {16'hAAAA, 1'b0};
        av[2] = {16'hAAAA, 1'b1};
        out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            {a, cin} = av[i];
            b = (i == 0) ? 16'h0001 : 16'h5555;
            step(acc, con, obs, lat);
            if (con) begin got[n] = obs; n++; end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10 && n < 3; i++) begin
            step(acc, con, obs, lat);
            if (con) begin got[n] = obs; n++; end
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL carry_count got %0d want 3", n);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== want[i]) begin
                    errors++;
                    $display("FAIL carry_case%0d got %h want %h", i, got[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_streaming();
        bit acc, con;
        logic [W+2:0] obs;
        int lat, n, last_cyc;
        out_ready = 1'b1;
        n = 0;
        last_cyc = 0;
        for (int i = 0; i < 30 && n < 10; i++) begin
            in_valid = (i < 10);
            a = 16'(i); b = 16'(3 * i); cin = 1'b0;
            step(acc, con, obs, lat);
            if (con) begin
                checks += 2;
                if (obs[W+1:2] !== 16'(4 * n)) begin
                    errors++;
                    $display("FAIL stream_sum got %h want %h", obs[W+1:2], 16'(4 * n));
                end
                if (lat !== 3 || (n > 0 && cyc != last_cyc + 1)) begin
                    errors++;
                    $display("FAIL stream_timing got lat=%0d gap=%0d want lat=3 gap=1", lat, cyc - last_cyc);
                end
                last_cyc = cyc;
                n++;
            end
        end
        checks++;
        if (n != 10) begin errors++; $display("FAIL stream_count got %0d want 10", n); end
        drain(1'b0);
    endtask

    task automatic test_backpressure();
        bit acc, con, have;
        logic [W+2:0] obs, held;
        int lat, n_acc;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        have  = 1'b0;
        n_acc = 0;
        held  = '0;
        for (int i = 0; i < 6; i++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            step(acc, con, obs, lat);
            if (acc) n_acc++;
            if (out_valid) begin
                if (have) begin
                    checks++;
                    if ({cout, sum, g_out, p_out} !== held) begin
                        errors++;
                        $display("FAIL bp_stable got %h want %h", {cout, sum, g_out, p_out}, held);
                    end
                end else begin
                    held = {cout, sum, g_out, p_out};
                    have = 1'b1;
                end
            end
        end
        checks += 3;
        if (n_acc != 3)       begin errors++; $display("FAIL bp_accepts got %0d want 3", n_acc); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        if (!have)            begin errors++; $display("FAIL bp_out_valid got 0 want 1"); end
        out_ready = 1'b1;
        for (int i = 0; i < 20 && n_acc < 5; i++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            step(acc, con, obs, lat);
            if (acc) n_acc++;
        end
        drain(1'b0);
    endtask

    task automatic test_reset_midflight();
        bit acc, con;
        logic [W+2:0] obs;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            step(acc, con, obs, lat);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(acc, con, obs, lat);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale got out_valid=%b want 0", out_valid); end
        end
        in_valid = 1'b1;
        a = 16'h0F0F; b = 16'h00F1; cin = 1'b1;
        step(acc, con, obs, lat);
        drain(1'b1);
    endtask

    task automatic test_random();
        bit acc, con;
        logic [W+2:0] obs;
        int lat, n;
        n = 0;
        for (int i = 0; i < 60000 && n < 10000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            step(acc, con, obs, lat);
            if (acc) n++;
        end
        checks++;
        if (n != 10000) begin errors++; $display("FAIL random_accepts got %0d want 10000", n); end
        drain(1'b0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0;
        test_reset();
        test_carry_chain();
        test_streaming();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
